zr_irq_ctrl: RTL and testbench
==============================

// Module: zr_irq_ctrl
// PURPOSE
// - Interrupt controller feeding the core's irq_i/irq_id_i inputs and consuming irq_ack_o/irq_id_o.
// - Collects NUM_SRC level/edge sources, fixed-priority arbitrates, holds one request until the core acks.
// - Sits inside zr_coreplex between peripherals and the core; software-visible via a small register port.
// PARAMETERS
// - NUM_SRC  16  number of interrupt sources, 1..32
// - ID_W     5   width of interrupt id; must satisfy 2**ID_W >= NUM_SRC
// - SYNC_EN  1   1: 2-flop synchronizer on src_i; 0: src_i already synchronous to clk
// PORTS
// - clk           in   1        clock
// - rst_n         in   1        asynchronous active-low reset
// - src_i         in   NUM_SRC  interrupt source lines, active high
// - reg_req_i     in   1        register access request
// - reg_we_i      in   1        1 = write, 0 = read
// - reg_addr_i    in   5        byte offset, word aligned
// - reg_wdata_i   in   32       write data
// - reg_gnt_o     out  1        grant; equals reg_req_i, same cycle
// - reg_rvalid_o  out  1        response valid, exactly 1 cycle after a granted access
// - reg_rdata_o   out  32       read data, valid with reg_rvalid_o; 0 for writes
// - irq_o         out  1        interrupt request to core (core irq_i)
// - irq_id_o      out  ID_W     id of requested interrupt (core irq_id_i)
// - irq_ack_i     in   1        core ack pulse (core irq_ack_o)
// - irq_ack_id_i  in   ID_W     id the core took (core irq_id_o)
// BEHAVIOUR
// - Reset: irq_o=0, irq_id_o=0, reg_rvalid_o=0, reg_rdata_o=0; PENDING/ENABLE/EDGE/STATUS=0; FSM IDLE.
// - Register map: 0x00 PENDING (R, W1C edge bits); 0x04 ENABLE (RW); 0x08 EDGE (RW, 1=edge);
//   0x0C SWSET (W1S into PENDING, reads 0); 0x10 STATUS {[31]ack_err sticky W1C, [8]busy, [ID_W-1:0]cur_id}.
// - Unmapped offsets: write ignored, read 0. Bits >= NUM_SRC read 0, writes ignored.
// - Pending: level source -> pending[i] = synced src[i] | swset_latch[i]; edge source -> set on rising edge
//   of synced src[i] (edge detect register), cleared by W1C or by ack with id i.
// - Level source swset_latch cleared by ack with id i or PENDING W1C.
// - Same cycle set (edge/SWSET) and clear (W1C/ack) on one bit: set wins, pending stays 1.
// - Candidate = lowest index i with pending[i] & enable[i] (zr_irq_prio_enc).
// - FSM IDLE: candidate exists -> REQ, register irq_id_o=candidate, irq_o=1 next cycle (latency 1 from pending).
// - FSM REQ: irq_id_o held stable while irq_o=1, even if a higher-priority source arrives.
//   - irq_ack_i & irq_ack_id_i==irq_id_o -> clear that pending, irq_o=0, go GAP.
//   - irq_ack_i & id mismatch -> set ack_err, still drop irq_o, go GAP; no pending cleared.
//   - no ack and registered source no longer pending&enabled -> irq_o=0, go IDLE (request withdrawn).
//   - ack and withdrawal same cycle: ack wins.
// - FSM GAP: one cycle with irq_o=0, then IDLE; guarantees core sees deassertion between requests.
// - busy = (state != IDLE); cur_id = irq_id_o.
// - ENABLE/EDGE written while REQ: take effect next cycle; may cause withdrawal per rule above.
// - Reset asserted mid-request: all state cleared immediately; irq_o drops asynchronously.
// - Sync latency: SYNC_EN=1 adds 2 cycles from src_i to pending.
// STRUCTURE
// - zr_irq_pkg: register offset localparams, STATUS bit positions, typedef enum {IDLE, REQ, GAP} irq_state_e.
// - Sub-module zr_irq_prio_enc: NUM_SRC-bit vector -> {valid, ID_W id}, lowest index first, combinational.
// - Top: synchronizer, edge detect, pending/enable/edge regs, FSM, register port.
// TESTING
// - Edge src 3 enabled, pulse src_i[3] 1 cycle -> irq_o=1, irq_id_o=3; ack id 3 -> PENDING[3]=0, irq_o low >=1 cycle.
// - Level src 0 and 5 high, both enabled -> id 0 first; ack 0 keeps PENDING[0]=1 while src high; drop src 0 -> id 5 next.
// - In REQ id 7, raise src 2 -> irq_id_o stays 7 until ack; then after GAP id 2 presented.
// - Level src 4 requested, deassert src_i[4] before ack -> irq_o=0, STATUS.busy=0, no ack_err.
// - Ack with id 9 while irq_id_o=1 -> STATUS=0x8000_0000 (ack_err set, busy 0), PENDING[1] stays 1; W1C clears ack_err.
// - Same cycle edge on src 6 and ack id 6 -> PENDING[6]=1, re-requested id 6 after GAP; SWSET 0x10 -> id 4 requested.

Source files
------------

// File: rtl/zr_irq_pkg.sv
// Shared definitions for the zr_irq interrupt controller: register map,
// STATUS field positions and the request FSM state type.
package zr_irq_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_PENDING = 5'h00;
    localparam logic [REG_ADDR_W-1:0] REG_ENABLE  = 5'h04;
    localparam logic [REG_ADDR_W-1:0] REG_EDGE    = 5'h08;
    localparam logic [REG_ADDR_W-1:0] REG_SWSET   = 5'h0C;
    localparam logic [REG_ADDR_W-1:0] REG_STATUS  = 5'h10;

    localparam int unsigned STAT_ERR_BIT  = 31;
    localparam int unsigned STAT_BUSY_BIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/zr_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of a request vector.
module zr_irq_prio_enc #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid_c,
    output logic [ID_W-1:0]    id_c
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        valid_c = 1'b0;
        id_c    = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                id_c    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/zr_irq_ctrl.sv
// Interrupt controller: synchronises level/edge sources, arbitrates by fixed
// priority and holds one request towards the core until it is acknowledged.
module zr_irq_ctrl #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned ID_W    = 5,
    parameter bit          SYNC_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [4:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic               reg_gnt_o,
    output logic               reg_rvalid_o,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    input  logic [ID_W-1:0]    irq_ack_id_i
);
    import zr_irq_pkg::*;

    localparam int unsigned PAD_W = 1 << ID_W;

    irq_state_e             state_q;
    logic                   ack_err_q;
    logic [NUM_SRC-1:0]     src_s;
    logic [NUM_SRC-1:0]     src_d;
    logic [NUM_SRC-1:0]     pend_q;
    logic [NUM_SRC-1:0]     enable_q;
    logic [NUM_SRC-1:0]     edge_q;
    logic [NUM_SRC-1:0]     pending;
    logic [NUM_SRC-1:0]     active;
    logic [NUM_SRC-1:0]     wdata_src;
    logic [NUM_SRC-1:0]     set_mask;
    logic [NUM_SRC-1:0]     clr_mask;
    logic [NUM_SRC-1:0]     ack_mask;
    logic [PAD_W-1:0]       act_pad;
    logic [PAD_W-1:0]       id_onehot;
    logic                   cand_valid;
    logic [ID_W-1:0]        cand_id;
    logic                   busy;
    logic                   wr;
    logic                   wr_pend;
    logic                   wr_enable;
    logic                   wr_edge;
    logic                   wr_swset;
    logic                   wr_status;
    logic                   in_req;
    logic                   ack_hit;
    logic                   ack_miss;
    logic [REG_DATA_W-1:0]  rd_data;
    logic                   unused_bits;

    // Optional two-flop synchroniser on the raw source lines.
    if (SYNC_EN) begin : g_sync
        logic [NUM_SRC-1:0] meta_q;
        logic [NUM_SRC-1:0] sync_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= '0;
                sync_q <= '0;
            end else begin
                meta_q <= src_i;
                sync_q <= meta_q;
            end
        end
        assign src_s = sync_q;
    end else begin : g_nosync
        assign src_s = src_i;
    end

    // pend_q is the edge-pending flop for edge bits and the SWSET latch for level bits.
    assign pending = (edge_q & pend_q) | (~edge_q & (src_s | pend_q));
    assign active  = pending & enable_q;
    assign act_pad = PAD_W'(active);
    assign busy    = (state_q != IDLE);

    zr_irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req     (active),
        .valid_c (cand_valid),
        .id_c    (cand_id)
    );

    assign wr        = reg_req_i & reg_we_i;
    assign wr_pend   = wr & (reg_addr_i == REG_PENDING);
    assign wr_enable = wr & (reg_addr_i == REG_ENABLE);
    assign wr_edge   = wr & (reg_addr_i == REG_EDGE);
    assign wr_swset  = wr & (reg_addr_i == REG_SWSET);
    assign wr_status = wr & (reg_addr_i == REG_STATUS);
    assign wdata_src = reg_wdata_i[NUM_SRC-1:0];

    assign in_req    = (state_q == REQ);
    assign ack_hit   = in_req & irq_ack_i & (irq_ack_id_i == irq_id_o);
    assign ack_miss  = in_req & irq_ack_i & (irq_ack_id_i != irq_id_o);
    assign id_onehot = PAD_W'(1) << irq_id_o;
    assign ack_mask  = ack_hit ? NUM_SRC'(id_onehot) : '0;

    // Sets are applied after clears so a coincident set keeps the bit pending.
    assign set_mask  = (edge_q & src_s & ~src_d) | (wr_swset ? wdata_src : '0);
    assign clr_mask  = ack_mask | (wr_pend ? wdata_src : '0);

    assign unused_bits = ^{reg_wdata_i, id_onehot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d    <= '0;
            pend_q   <= '0;
            enable_q <= '0;
            edge_q   <= '0;
        end else begin
            src_d  <= src_s;
            pend_q <= (pend_q & ~clr_mask) | set_mask;
            if (wr_enable) begin
                enable_q <= wdata_src;
            end
            if (wr_edge) begin
                edge_q <= wdata_src;
            end
        end
    end

    // Request FSM; irq_id_o is frozen while irq_o is high and zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            ack_err_q <= 1'b0;
        end else begin
            if (ack_miss) begin
                ack_err_q <= 1'b1;
            end else if (wr_status && reg_wdata_i[STAT_ERR_BIT]) begin
                ack_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (cand_valid) begin
                        state_q  <= REQ;
                        irq_o    <= 1'b1;
                        irq_id_o <= cand_id;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state_q  <= GAP;
                        irq_o    <= 1'b0;
                        irq_id_o <= '0;
                    end else if (!act_pad[irq_id_o]) begin
                        state_q  <= IDLE;
                        irq_o    <= 1'b0;
                        irq_id_o <= '0;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    irq_o    <= 1'b0;
                    irq_id_o <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr_i)
            REG_PENDING: rd_data = REG_DATA_W'(pending);
            REG_ENABLE:  rd_data = REG_DATA_W'(enable_q);
            REG_EDGE:    rd_data = REG_DATA_W'(edge_q);
            REG_STATUS: begin
                rd_data[STAT_ERR_BIT]  = ack_err_q;
                rd_data[STAT_BUSY_BIT] = busy;
                rd_data[ID_W-1:0]      = irq_id_o;
            end
            default:     rd_data = '0;
        endcase
    end

    assign reg_gnt_o = reg_req_i;

    // Single-cycle response; write responses carry zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= (reg_req_i && !reg_we_i) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_zr_irq_ctrl.sv
// Bench for zr_irq_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the controller.
module tb_zr_irq_ctrl;

    localparam int unsigned NS = 16;
    localparam int unsigned IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] src_i;
    logic          reg_req_i;
    logic          reg_we_i;
    logic [4:0]    reg_addr_i;
    logic [31:0]   reg_wdata_i;
    logic          reg_gnt_o;
    logic          reg_rvalid_o;
    logic [31:0]   reg_rdata_o;
    logic          irq_o;
    logic [IW-1:0] irq_id_o;
    logic          irq_ack_i;
    logic [IW-1:0] irq_ack_id_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zr_irq_ctrl #(
        .NUM_SRC (NS),
        .ID_W    (IW),
        .SYNC_EN (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_i        (src_i),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_gnt_o    (reg_gnt_o),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sources seen two cycles late, per-bit pending rules,
    // one held request (m_req = -1 when none) and a one-cycle gap after an ack.
    logic [NS-1:0] m1, m2, mprev, men, medg, mepend, mswl;
    bit            merr;
    int            m_req;
    int            m_gap;
    logic          m_rvalid;
    logic [31:0]   m_rdata;

    task automatic model_step();
        logic [NS-1:0] pv, av, w, swset_w, w1c_w, ackclr, setv, clrv;
        logic [31:0]   rd;
        int            cand;
        bit            errset;
        bit            wr;
        if (rst_n !== 1'b1) begin
            m1 = '0; m2 = '0; mprev = '0; men = '0; medg = '0; mepend = '0; mswl = '0;
            merr = 1'b0; m_req = -1; m_gap = 0; m_rvalid = 1'b0; m_rdata = '0;
            return;
        end
        for (int i = 0; i < int'(NS); i++)
            pv[i] = medg[i] ? mepend[i] : (m2[i] | mswl[i]);
        av = pv & men;
        cand = -1;
        for (int i = int'(NS) - 1; i >= 0; i--)
            if (av[i]) cand = i;
        rd = '0;
        if (reg_req_i && !reg_we_i) begin
            case (reg_addr_i)
                5'h00:   rd = 32'(pv);
                5'h04:   rd = 32'(men);
                5'h08:   rd = 32'(medg);
                5'h10:   rd = (merr ? 32'h8000_0000 : 32'h0)
                            | ((m_req >= 0 || m_gap > 0) ? 32'h100 : 32'h0)
                            | (m_req >= 0 ? 32'(m_req) : 32'h0);
                default: rd = '0;
            endcase
        end
        wr      = reg_req_i && reg_we_i;
        w       = reg_wdata_i[NS-1:0];
        swset_w = (wr && reg_addr_i == 5'h0C) ? w : '0;
        w1c_w   = (wr && reg_addr_i == 5'h00) ? w : '0;
        ackclr  = '0;
        errset  = 1'b0;
        if (m_req >= 0) begin
            if (irq_ack_i) begin
                if (int'(irq_ack_id_i) == m_req) ackclr[m_req] = 1'b1;
                else errset = 1'b1;
                m_req = -1;
                m_gap = 1;
            end else if (!av[m_req]) begin
                m_req = -1;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
        end else if (cand >= 0) begin
            m_req = cand;
        end
        setv   = (medg & m2 & ~mprev) | swset_w;
        clrv   = ackclr | w1c_w;
        mepend = ((mepend & ~clrv) | setv) & medg;
        mswl   = ((mswl & ~clrv) | swset_w) & ~medg;
        if (wr && reg_addr_i == 5'h10 && reg_wdata_i[31]) merr = 1'b0;
        if (errset) merr = 1'b1;
        if (wr && reg_addr_i == 5'h04) men = w;
        if (wr && reg_addr_i == 5'h08) medg = w;
        m_rvalid = reg_req_i;
        m_rdata  = rd;
        mprev = m2;
        m2    = m1;
        m1    = src_i;
    endtask

    // Compare process: advance the model on each rising edge, check 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("irq_o", 32'(irq_o), 32'(m_req >= 0));
            chk("irq_id_o", 32'(irq_id_o), (m_req >= 0) ? 32'(m_req) : 32'h0);
            chk("reg_rvalid_o", 32'(reg_rvalid_o), 32'(m_rvalid));
            chk("reg_rdata_o", reg_rdata_o, m_rdata);
            chk("reg_gnt_o", 32'(reg_gnt_o), 32'(reg_req_i));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        src_i = '0; reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        irq_ack_i = 1'b0; irq_ack_id_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
        @(negedge clk);
        reg_req_i = 1'b0; reg_we_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
        reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a; reg_wdata_i = '0;
        @(negedge clk);
        d = reg_rdata_o;
        reg_req_i = 1'b0;
    endtask

    task automatic ack(input logic [IW-1:0] id);
        irq_ack_i = 1'b1; irq_ack_id_i = id;
        @(negedge clk);
        irq_ack_i = 1'b0;
    endtask

    task automatic wait_id(input string nm, input int id, input int budget);
        int n = 0;
        while (!(irq_o === 1'b1 && irq_id_o === IW'(id)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {26'h0, irq_o, irq_id_o}, {26'h0, 1'b1, IW'(id)});
    endtask

    task automatic wait_low(input string nm, input int budget);
        int n = 0;
        while (irq_o !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(irq_o), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        do_reset();

        // Reset values of every register
        for (int k = 0; k < 5; k++) begin
            reg_rd(5'(k * 4), rd);
            chk("reset_reg", rd, 32'h0);
        end

        // Edge source 3, single-cycle pulse
        reg_wr(5'h08, 32'h8);
        reg_wr(5'h04, 32'h8);
        src_i = 16'h0008;
        @(negedge clk);
        src_i = '0;
        wait_id("edge3_req", 3, 10);
        chk("model_pin_id3", 32'(m_req), 32'd3);
        ack(5'd3);
        chk("edge3_drop", 32'(irq_o), 32'h0);
        reg_rd(5'h00, rd);
        chk("edge3_pending_clr", rd, 32'h0);

        // Level sources 0 and 5
        do_reset();
        reg_wr(5'h04, 32'h21);
        src_i = 16'h0021;
        wait_id("lvl_id0", 0, 10);
        ack(5'd0);
        reg_rd(5'h00, rd);
        chk("lvl_pending_kept", rd, 32'h21);
        src_i = 16'h0020;
        wait_id("lvl_id5", 5, 20);
        src_i = '0;
        wait_low("lvl_withdraw5", 10);

        // Held id is not pre-empted by a higher-priority arrival
        do_reset();
        reg_wr(5'h04, 32'hFFFF);
        src_i = 16'h0080;
        wait_id("hold_id7", 7, 10);
        src_i = 16'h0084;
        repeat (6) @(negedge clk);
        chk("hold_still7", {26'h0, irq_o, irq_id_o}, {26'h0, 1'b1, 5'd7});
        ack(5'd7);
        chk("hold_gap", 32'(irq_o), 32'h0);
        wait_id("hold_then2", 2, 10);
        src_i = '0;
        wait_low("hold_withdraw", 10);

        // Withdrawal of a level request
        do_reset();
        reg_wr(5'h04, 32'h10);
        src_i = 16'h0010;
        wait_id("wd_id4", 4, 10);
        src_i = '0;
        wait_low("wd_low", 10);
        reg_rd(5'h10, rd);
        chk("wd_status", rd, 32'h0);

        // Mismatched ack sets ack_err; ENABLE cleared in the same cycle
        do_reset();
        reg_wr(5'h04, 32'h2);
        reg_wr(5'h0C, 32'h2);
        wait_id("err_id1", 1, 10);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd9;
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 5'h04; reg_wdata_i = 32'h0;
        @(negedge clk);
        irq_ack_i = 1'b0; reg_req_i = 1'b0; reg_we_i = 1'b0;
        repeat (3) @(negedge clk);
        reg_rd(5'h10, rd);
        chk("err_status", rd, 32'h8000_0000);
        chk("model_pin_err", 32'(merr), 32'h1);
        reg_rd(5'h00, rd);
        chk("err_pending_kept", rd, 32'h2);
        reg_wr(5'h10, 32'h8000_0000);
        reg_rd(5'h10, rd);
        chk("err_w1c", rd, 32'h0);

        // Edge on src 6 coincident with ack of id 6: set wins
        do_reset();
        reg_wr(5'h08, 32'h40);
        reg_wr(5'h04, 32'h50);
        src_i = 16'h0040;
        @(negedge clk);
        src_i = '0;
        wait_id("coin_id6", 6, 10);
        src_i = 16'h0040;
        @(negedge clk);
        src_i = '0;
        @(negedge clk);
        ack(5'd6);
        reg_rd(5'h00, rd);
        chk("coin_pending6", rd, 32'h40);
        wait_id("coin_rereq6", 6, 10);
        ack(5'd6);
        repeat (2) @(negedge clk);
        reg_wr(5'h0C, 32'h10);
        wait_id("swset_id4", 4, 10);
        ack(5'd4);

        // Reset during a request drops irq_o without waiting for a clock
        reg_wr(5'h04, 32'h1);
        src_i = 16'h0001;
        wait_id("arst_req", 0, 10);
        rst_n = 1'b0;
        src_i = '0;
        #1;
        chk("arst_irq_low", 32'(irq_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with a fixed EDGE configuration
        do_reset();
        reg_wr(5'h08, 32'($urandom_range(0, 65535)));
        reg_wr(5'h04, 32'($urandom_range(0, 65535)));
        for (int c = 0; c < 4000; c++) begin
            reg_req_i = 1'b0; reg_we_i = 1'b0; irq_ack_i = 1'b0;
            src_i = src_i ^ NS'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 4) == 0) begin
                reg_req_i   = 1'b1;
                reg_addr_i  = 5'($urandom_range(0, 7) << 2);
                reg_we_i    = 1'($urandom_range(0, 1));
                if (reg_addr_i == 5'h08) reg_we_i = 1'b0;
                reg_wdata_i = $urandom;
            end
            if (irq_o && $urandom_range(0, 3) == 0) begin
                irq_ack_i    = 1'b1;
                irq_ack_id_i = ($urandom_range(0, 7) == 0) ? 5'($urandom) : irq_id_o;
            end else if (!irq_o && $urandom_range(0, 31) == 0) begin
                irq_ack_i    = 1'b1;
                irq_ack_id_i = 5'($urandom);
            end
            @(negedge clk);
        end
        reg_req_i = 1'b0; reg_we_i = 1'b0; irq_ack_i = 1'b0; src_i = '0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
